// File: rtl/kernel_pkg.sv
// -----------------------------------------------------------------------------
// kernel_pkg
// Shared definitions for the kernel write-back path: the writer FSM state
// encoding and the default frame and datapath geometry.
// -----------------------------------------------------------------------------
package kernel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } kstate_t;

    localparam int K_DATA_W     = 17;     // kernel result width, two's complement
    localparam int K_OUT_W      = 8;      // output pixel width
    localparam int K_ADDR_W     = 16;     // output RAM address width
    localparam int K_FRAME_PIX  = 65536;  // 256x256 frame
    localparam int K_FIFO_DEPTH = 4;      // result buffer entries

endpackage

// File: rtl/result_fifo.sv
// -----------------------------------------------------------------------------
// result_fifo
// Small synchronous FIFO that buffers pixels between the kernel result strobe
// and the output RAM write port.
//
// Ports:
//   clk    in   rising-edge clock
//   n_rst  in   asynchronous active-low reset
//   flush  in   empty the FIFO (has priority over push/pop)
//   push   in   write din at the tail
//   pop    in   drop the head entry
//   din    in   W-bit data to push
//   dout   out  W-bit head entry
//   full   out  all DEPTH entries occupied
//   empty  out  no entries occupied
//
// A push while full is accepted only when a pop happens in the same cycle.
// Storage is reset so that dout reads zero straight out of reset.
// -----------------------------------------------------------------------------
module result_fifo
    import kernel_pkg::*;
#(
    parameter int W     = K_OUT_W,
    parameter int DEPTH = K_FIFO_DEPTH
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kernel_result_writer.sv
// -----------------------------------------------------------------------------
// kernel_result_writer
// Write-back end of the 3x3 filter pipeline. Takes the per-pixel result strobes
// of the kernel engine, buffers them, optionally clamps them to the pixel range
// and writes them sequentially into the output frame RAM starting at address 0.
//
// Ports:
//   clk         in   rising-edge clock
//   n_rst       in   asynchronous active-low reset
//   start       in   pulse: begin a new frame (ignored while busy)
//   in_valid    in   result strobe from the kernel engine (cannot be stalled)
//   in_data     in   DATA_W-bit kernel result
//   in_ready    out  status: buffer not full
//   wr_ready    in   RAM accepts a write this cycle
//   wr_en       out  RAM write enable
//   wr_addr     out  ADDR_W-bit RAM write address
//   wr_data     out  OUT_W-bit RAM write data
//   busy        out  frame in progress
//   frame_done  out  pulse one cycle after the last pixel of the frame is written
//   overflow    out  sticky: a result was dropped during the frame
//
// Build option: define KERNEL_WR_CLAMP_EN to saturate the signed result into
// 0..2**OUT_W-1; otherwise the low OUT_W bits are written.
// -----------------------------------------------------------------------------
module kernel_result_writer
    import kernel_pkg::*;
#(
    parameter int DATA_W     = K_DATA_W,
    parameter int OUT_W      = K_OUT_W,
    parameter int ADDR_W     = K_ADDR_W,
    parameter int FRAME_PIX  = K_FRAME_PIX,
    parameter int FIFO_DEPTH = K_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [OUT_W-1:0]  wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int CNT_W = $clog2(FRAME_PIX) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIX - 1);

    kstate_t          state;
    logic [CNT_W-1:0] pix_cnt;
    logic [OUT_W-1:0] pix_in;
    logic [OUT_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_flush;
    logic             in_run;
    logic             accept;
    logic             last_wr;
    logic             start_run;

`ifdef KERNEL_WR_CLAMP_EN
    localparam logic signed [DATA_W-1:0] PIX_MAX = DATA_W'((1 << OUT_W) - 1);

    function automatic logic [OUT_W-1:0] clamp_pix(input logic signed [DATA_W-1:0] d);
        if (d < 0) begin
            return '0;
        end else if (d > PIX_MAX) begin
            return '1;
        end else begin
            return d[OUT_W-1:0];
        end
    endfunction

    assign pix_in = clamp_pix(in_data);
`else
    logic unused_in_hi;

    assign pix_in       = in_data[OUT_W-1:0];
    assign unused_in_hi = ^in_data[DATA_W-1:OUT_W];
`endif

    assign in_run    = (state == ST_RUN);
    assign wr_en     = in_run && !fifo_empty;
    assign accept    = wr_en && wr_ready;
    assign last_wr   = accept && (pix_cnt == LAST_CNT);
    assign start_run = start && !in_run;

    // A full buffer still takes a strobe when the head leaves in the same cycle.
    // Strobes arriving with the final write belong to no frame and are dropped.
    assign fifo_push  = in_run && in_valid && (!fifo_full || accept) && !last_wr;
    assign fifo_flush = start_run || last_wr;

    assign wr_data  = fifo_dout;
    assign in_ready = !fifo_full;
    assign busy     = in_run;

    result_fifo #(
        .W     (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (accept),
        .din   (pix_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            pix_cnt    <= '0;
            wr_addr    <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_wr;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state    <= ST_RUN;
                        pix_cnt  <= '0;
                        wr_addr  <= '0;
                        overflow <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (in_valid && fifo_full && !accept) begin
                        overflow <= 1'b1;
                    end
                    if (accept) begin
                        // Address stops at the last pixel instead of wrapping.
                        if (pix_cnt == LAST_CNT) begin
                            state <= ST_DONE;
                        end else begin
                            pix_cnt <= pix_cnt + CNT_W'(1);
                            wr_addr <= wr_addr + ADDR_W'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
